// File: rtl/synth_voice.sv
// Single-voice synthesiser: phase-accumulator oscillator (saw/square/triangle/noise),
// ADSR envelope, two-stage amplitude scaling and a first-order PDM output.
module synth_voice #(
   parameter int unsigned CLKSPEED = 50_000_000,
   parameter int unsigned TICK_DIV = 1024,
   parameter int unsigned DW       = 10,
   parameter int unsigned PHASE_W  = 24,
   parameter int unsigned FREQ_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gate,
   input  logic [1:0]        wave_sel,
   input  logic [FREQ_W-1:0] freq_word,
   input  logic [15:0]       amp_in,
   input  logic [DW-1:0]     attack_rate,
   input  logic [DW-1:0]     decay_rate,
   input  logic [DW-1:0]     sustain_lvl,
   input  logic [DW-1:0]     release_rate,
   output logic [DW-1:0]     level,
   output logic [DW-1:0]     env,
   output logic [2:0]        env_state,
   output logic              dout
);

   localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [DW-1:0] ENV_MAX   = '1;

   generate
      if (TICK_DIV < 2 || PHASE_W < DW || FREQ_W > PHASE_W || DW < 2 || DW > 16 ||
          CLKSPEED < TICK_DIV) begin : g_param_check
         $error("synth_voice: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StAttack  = 3'd1,
      StDecay   = 3'd2,
      StSustain = 3'd3,
      StRelease = 3'd4
   } env_state_t;

   logic [CW-1:0]      cnt_q;
   logic               tick, tick_q;
   logic [PHASE_W-1:0] phase_q;
   logic [15:0]        lfsr_q;
   logic               lfsr_fb;
   logic [DW-1:0]      env_q, env_d;
   env_state_t         state_q, state_d;
   logic [DW:0]        att_sum, dec_floor;
   logic [DW-1:0]      p, tri_w, wave;
   logic [2*DW-1:0]    prod_env;
   logic [DW-1:0]      m1;
   logic [DW+15:0]     prod_amp;
   logic [DW-1:0]      level_q, acc_q;
   logic [DW:0]        pdm_sum;
   logic               dout_q;

   assign tick    = (cnt_q == TICK_LAST);
   assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

   // Envelope next-state; only committed on a tick, so gate is effectively sampled there.
   assign att_sum   = {1'b0, env_q} + {1'b0, attack_rate};
   assign dec_floor = {1'b0, sustain_lvl} + {1'b0, decay_rate};

   always_comb begin
      state_d = state_q;
      env_d   = env_q;
      unique case (state_q)
         StIdle: begin
            if (gate) state_d = StAttack;
         end
         StAttack: begin
            if (!gate) begin
               state_d = StRelease;
            end else if (att_sum >= {1'b0, ENV_MAX}) begin
               env_d   = ENV_MAX;
               state_d = StDecay;
            end else begin
               env_d = att_sum[DW-1:0];
            end
         end
         StDecay: begin
            if (!gate) begin
               state_d = StRelease;
            end else if ({1'b0, env_q} <= dec_floor) begin
               env_d   = sustain_lvl;
               state_d = StSustain;
            end else begin
               env_d = env_q - decay_rate;
            end
         end
         StSustain: begin
            if (!gate) state_d = StRelease;
            else       env_d   = sustain_lvl;
         end
         StRelease: begin
            if (gate) begin
               state_d = StAttack;
            end else if (env_q <= release_rate) begin
               env_d   = '0;
               state_d = StIdle;
            end else begin
               env_d = env_q - release_rate;
            end
         end
         default: begin
            state_d = StIdle;
            env_d   = '0;
         end
      endcase
   end

   assign p     = phase_q[PHASE_W-1 -: DW];
   assign tri_w = {p[DW-2:0], 1'b0};

   always_comb begin
      wave = p;
      case (wave_sel)
         2'd0: wave = p;
         2'd1: wave = {DW{phase_q[PHASE_W-1]}};
         2'd2: wave = phase_q[PHASE_W-1] ? ~tri_w : tri_w;
         2'd3: wave = lfsr_q[15 -: DW];
         default: wave = p;
      endcase
   end

   assign prod_env = {{DW{1'b0}}, wave} * {{DW{1'b0}}, env_q};
   assign m1       = DW'(prod_env >> DW);
   assign prod_amp = {16'b0, m1} * {{DW{1'b0}}, amp_in};
   assign pdm_sum  = {1'b0, acc_q} + {1'b0, level_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         tick_q  <= 1'b0;
         phase_q <= '0;
         lfsr_q  <= 16'hACE1;
         env_q   <= '0;
         state_q <= StIdle;
         level_q <= '0;
         acc_q   <= '0;
         dout_q  <= 1'b0;
      end else begin
         cnt_q  <= tick ? '0 : cnt_q + CW'(1);
         tick_q <= tick;
         if (tick) begin
            phase_q <= phase_q + PHASE_W'(freq_word);
            lfsr_q  <= {lfsr_q[14:0], lfsr_fb};
            env_q   <= env_d;
            state_q <= state_d;
         end
         // Mix one clock after the tick so it sees the freshly advanced phase/env/LFSR.
         if (tick_q) level_q <= DW'(prod_amp >> 16);
         acc_q  <= pdm_sum[DW-1:0];
         dout_q <= pdm_sum[DW];
      end
   end

   assign level     = level_q;
   assign env       = env_q;
   assign env_state = state_q;
   assign dout      = dout_q;

endmodule

// File: tb/tb_synth_voice.sv
// Bench for synth_voice: ADSR vector table, hand-written corner sequences and randomized
// stimulus, all checked against a tick-level behavioural model.
module tb_synth_voice;

   localparam int TD = 4;
   localparam int IDLE = 0, ATK = 1, DEC = 2, SUS = 3, REL = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        gate;
   logic [1:0]  wave_sel;
   logic [15:0] freq_word;
   logic [15:0] amp_in;
   logic [9:0]  attack_rate, decay_rate, sustain_lvl, release_rate;
   logic [9:0]  level, env;
   logic [2:0]  env_state;
   logic        dout;

   always #5 clk = ~clk;

   synth_voice #(
      .CLKSPEED(50_000_000),
      .TICK_DIV(TD),
      .DW(10),
      .PHASE_W(16),
      .FREQ_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gate(gate),
      .wave_sel(wave_sel),
      .freq_word(freq_word),
      .amp_in(amp_in),
      .attack_rate(attack_rate),
      .decay_rate(decay_rate),
      .sustain_lvl(sustain_lvl),
      .release_rate(release_rate),
      .level(level),
      .env(env),
      .env_state(env_state),
      .dout(dout)
   );

   int vectors = 0;
   int miscompares = 0;

   // ---------------- behavioural reference model ----------------
   typedef struct { int st; int env; } env_s;

   function automatic env_s env_next(int st, int e, bit g, int ar, int dr, int sl, int rr);
      env_s r;
      r.st = st; r.env = e;
      case (st)
         IDLE: if (g) r.st = ATK;
         ATK: begin
            if (!g) r.st = REL;
            else if (e + ar >= 1023) begin r.env = 1023; r.st = DEC; end
            else r.env = e + ar;
         end
         DEC: begin
            if (!g) r.st = REL;
            else if (e - dr <= sl) begin r.env = sl; r.st = SUS; end
            else r.env = e - dr;
         end
         SUS: begin
            if (!g) r.st = REL;
            else r.env = sl;
         end
         REL: begin
            if (g) r.st = ATK;
            else if (e - rr <= 0) begin r.env = 0; r.st = IDLE; end
            else r.env = e - rr;
         end
         default: r.st = IDLE;
      endcase
      return r;
   endfunction

   function automatic int lfsr_next(int x);
      int fb;
      fb = ((x >> 15) ^ (x >> 13) ^ (x >> 12) ^ (x >> 10)) & 1;
      return ((x << 1) & 16'hFFFF) | fb;
   endfunction

   function automatic int mix_ref(int ph, int e, int lf, int ws, int amp);
      longint w, t, m1;
      int p;
      bit msb;
      p = ph / 64;
      msb = (ph >= 32768);
      case (ws)
         0: w = p;
         1: w = msb ? 1023 : 0;
         2: begin t = (p * 2) % 1024; w = msb ? 1023 - t : t; end
         default: w = lf / 64;
      endcase
      m1 = (w * e) / 1024;
      return int'((m1 * amp) / 65536);
   endfunction

   int   m_cnt, m_phase, m_lfsr, m_env, m_st, m_level, m_acc, m_mix;
   bit   m_dout, m_tick_q;
   env_s m_nx;

   always_comb m_nx = env_next(m_st, m_env, gate, attack_rate, decay_rate, sustain_lvl,
                               release_rate);
   always_comb m_mix = mix_ref(m_phase, m_env, m_lfsr, wave_sel, amp_in);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt <= 0; m_phase <= 0; m_lfsr <= 16'hACE1; m_env <= 0; m_st <= IDLE;
         m_level <= 0; m_acc <= 0; m_dout <= 1'b0; m_tick_q <= 1'b0;
      end else begin
         m_level  <= m_tick_q ? m_mix : m_level;
         m_acc    <= (m_acc + m_level) % 1024;
         m_dout   <= ((m_acc + m_level) >= 1024);
         m_tick_q <= (m_cnt == TD - 1);
         m_cnt    <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
         if (m_cnt == TD - 1) begin
            m_phase <= (m_phase + freq_word) % 65536;
            m_lfsr  <= lfsr_next(m_lfsr);
            m_env   <= m_nx.env;
            m_st    <= m_nx.st;
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("model_level", level, m_level);
      chk("model_env", env, m_env);
      chk("model_state", env_state, m_st);
      chk("model_dout", dout, m_dout);
   endtask

   task automatic wait_tick();
      bit seen = 1'b0;
      for (int i = 0; i < 2 * TD; i++) begin
         step();
         if (m_tick_q) begin seen = 1'b1; break; end
      end
      if (!seen) chk("tick_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct { bit g; int env; int st; } adsr_vec_t;
   adsr_vec_t tbl[29];

   int ones, prev, n, lf, exp_lvl, drops;

   initial begin
      rst = 1'b1; gate = 1'b0; wave_sel = 2'd0; freq_word = '0; amp_in = 16'hFFFF;
      attack_rate = 10'd256; decay_rate = 10'd100; sustain_lvl = 10'd600;
      release_rate = 10'd300;

      tbl[0]  = '{1, 0, ATK};    tbl[1]  = '{1, 256, ATK};  tbl[2]  = '{1, 512, ATK};
      tbl[3]  = '{1, 768, ATK};  tbl[4]  = '{1, 1023, DEC}; tbl[5]  = '{1, 923, DEC};
      tbl[6]  = '{1, 823, DEC};  tbl[7]  = '{1, 723, DEC};  tbl[8]  = '{1, 623, DEC};
      tbl[9]  = '{1, 600, SUS};  tbl[10] = '{1, 600, SUS};  tbl[11] = '{0, 600, REL};
      tbl[12] = '{0, 300, REL};  tbl[13] = '{0, 0, IDLE};   tbl[14] = '{0, 0, IDLE};
      tbl[15] = '{1, 0, ATK};    tbl[16] = '{1, 256, ATK};  tbl[17] = '{1, 512, ATK};
      tbl[18] = '{1, 768, ATK};  tbl[19] = '{1, 1023, DEC}; tbl[20] = '{1, 923, DEC};
      tbl[21] = '{1, 823, DEC};  tbl[22] = '{1, 723, DEC};  tbl[23] = '{1, 623, DEC};
      tbl[24] = '{1, 600, SUS};  tbl[25] = '{0, 600, REL};  tbl[26] = '{0, 300, REL};
      tbl[27] = '{1, 300, ATK};  tbl[28] = '{1, 556, ATK};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset_level", level, 0);
      chk("reset_env", env, 0);
      chk("reset_state", env_state, IDLE);
      chk("reset_dout", dout, 0);

      // ADSR envelope sequence including release-to-idle and retrigger from RELEASE
      for (int i = 0; i < 29; i++) begin
         gate = tbl[i].g;
         wait_tick();
         chk($sformatf("adsr_env[%0d]", i), env, tbl[i].env);
         chk($sformatf("adsr_state[%0d]", i), env_state, tbl[i].st);
      end

      // Run to SUSTAIN with a live noise signal, then reset mid-cycle
      wave_sel = 2'd3;
      repeat (8) wait_tick();
      chk("pre_reset_state", env_state, SUS);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreset_level", level, 0);
      chk("midreset_env", env, 0);
      chk("midreset_state", env_state, IDLE);
      chk("midreset_dout", dout, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_tick();
      chk("restart_state", env_state, ATK);
      chk("restart_env", env, 0);

      // Saw at full envelope and amplitude: monotone ramp with a single wrap at tick 1024
      do_reset();
      wave_sel = 2'd0; freq_word = 16'd64; attack_rate = 10'd1023; decay_rate = 10'd0;
      sustain_lvl = 10'd1023; amp_in = 16'hFFFF; gate = 1'b1;
      drops = 0; prev = 0;
      for (int t = 1; t <= 1100; t++) begin
         wait_tick();
         step();
         if (t >= 4 && level < prev) drops++;
         if (t == 1023) chk("saw_top", level, 1021);
         if (t == 1024) chk("saw_wrap", level, 0);
         prev = level;
      end
      chk("saw_drops", drops, 1);

      // PDM density: level held at exactly 512, then at 0
      do_reset();
      wave_sel = 2'd1; freq_word = 16'd32768; attack_rate = 10'd1023; decay_rate = 10'd1023;
      sustain_lvl = 10'd514; amp_in = 16'hFFFF; gate = 1'b1;
      wait_tick();
      freq_word = 16'd0;
      repeat (5) wait_tick();
      chk("pdm_level", level, 512);
      ones = 0;
      for (int c = 0; c < 1024; c++) begin
         step();
         ones += dout;
      end
      chk("pdm_ones_512", ones, 512);
      amp_in = 16'h0000;
      repeat (2) wait_tick();
      ones = 0;
      for (int c = 0; c < 1024; c++) begin
         step();
         ones += dout;
      end
      chk("pdm_ones_0", ones, 0);

      // Square with period 4 ticks at full envelope/amplitude
      do_reset();
      wave_sel = 2'd1; freq_word = 16'd16384; amp_in = 16'hFFFF; decay_rate = 10'd0;
      sustain_lvl = 10'd1023; attack_rate = 10'd1023; gate = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         wait_tick();
         step();
         if (t >= 4) chk($sformatf("square[%0d]", t), level, ((t % 4) >= 2) ? 1021 : 0);
      end

      // Noise from the LFSR seed
      do_reset();
      wave_sel = 2'd3;
      lf = 16'hACE1;
      for (int t = 1; t <= 16; t++) begin
         wait_tick();
         step();
         lf = lfsr_next(lf);
         exp_lvl = (((lf / 64) * 1023 / 1024) * 65535) / 65536;
         if (t >= 3) chk($sformatf("noise[%0d]", t), level, exp_lvl);
      end

      // Randomized segments against the model
      do_reset();
      for (int s = 0; s < 40; s++) begin
         gate         = ($urandom_range(0, 3) != 0);
         wave_sel     = 2'($urandom_range(0, 3));
         freq_word    = 16'($urandom_range(0, 65535));
         amp_in       = 16'($urandom_range(0, 65535));
         attack_rate  = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
         decay_rate   = 10'($urandom_range(0, 1023));
         sustain_lvl  = 10'($urandom_range(0, 1023));
         release_rate = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(1, 400));
         n = $urandom_range(2, 40);
         repeat (n) wait_tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/synth_voice.md
Name: synth_voice

Overview:
Parametrised single-voice synthesiser and the next generation of the existing fixed saw/sine voice.
- Phase-accumulator oscillator with run-time waveform select (saw, square, triangle, LFSR noise).
- Gate-driven ADSR envelope FSM.
- Two-stage amplitude scaling (envelope, then external amp_in).
- First-order PDM output stage, feeding the board audio pin directly.

Parameters:
CLKSPEED, 50_000_000, system clock in Hz (documentation/derivation only)
TICK_DIV, 1024, clk cycles per sample tick (>=2)
DW, 10, sample, envelope and PDM data width
PHASE_W, 24, phase accumulator width (>= DW)
FREQ_W, 16, phase increment width (<= PHASE_W)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
gate  in  1  note on (1) / off (0), synchronous to clk
wave_sel  in  2  0=saw 1=square 2=triangle 3=noise
freq_word  in  FREQ_W  phase increment per sample tick
amp_in  in  16  master amplitude, 16'hFFFF ~ unity
attack_rate  in  DW  envelope increment per tick in ATTACK
decay_rate  in  DW  envelope decrement per tick in DECAY
sustain_lvl  in  DW  sustain envelope level
release_rate  in  DW  envelope decrement per tick in RELEASE
level  out  DW  registered mixed sample
env  out  DW  current envelope value
env_state  out  3  0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
dout  out  1  PDM bit stream

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - tick counter=0, phase=0, LFSR=16'hACE1, env=0, env_state=IDLE, level=0, PDM accumulator=0, dout=0.
  - Reset asserted mid-note forces all of the above the same cycle, regardless of gate.
- Tick generator: counter runs 0..TICK_DIV-1; tick=1 for one cycle when counter==TICK_DIV-1, then the counter wraps to 0.
- On tick:
  - phase <= phase + zero-extended freq_word, wrapping modulo 2^PHASE_W.
  - LFSR advances one step: x^16+x^14+x^13+x^11, shift left, feedback into bit 0.
- Waveform, combinational from the registered phase; p = phase[PHASE_W-1 -: DW]:
  - saw = p.
  - square = all ones if phase MSB=1, else 0.
  - triangle = {p[DW-2:0],1'b0} when MSB=0, else bitwise inverse of that.
  - noise = LFSR[15 -: DW].
- Gate is sampled only on tick. Envelope FSM updates on tick:
  - IDLE: gate=1 -> ATTACK; env stays 0.
  - ATTACK: env += attack_rate, saturating at 2^DW-1. On reaching 2^DW-1 -> DECAY. attack_rate=0 holds env.
  - DECAY: env -= decay_rate, floored at sustain_lvl. On reaching sustain_lvl -> SUSTAIN.
  - SUSTAIN: env <= sustain_lvl (follows live changes).
  - gate=0 in ATTACK/DECAY/SUSTAIN -> RELEASE. env is unchanged on the transition tick.
  - RELEASE: env -= release_rate, floored at 0. On reaching 0 -> IDLE. gate=1 in RELEASE -> ATTACK from the current env (no restart from 0).
  - Gate takes priority over level-reached transitions on the same tick.
- Mixing: m1 = (wave * env) >> DW; level <= (m1 * amp_in) >> 16.
  - Full-width products, truncation, no rounding.
  - level registers on the cycle after tick, using post-tick phase/env/LFSR. Latency tick -> level = 1 clk.
- PDM runs every clk: acc(DW+1 bits) <= {1'b0, acc[DW-1:0]} + level; dout <= carry bit of the new sum (registered).
  - Over 2^DW consecutive clocks with constant level L, the ones count is exactly L.
- wave_sel, freq_word and the rate inputs may change any time; the new values take effect at the next tick.

Test Plan:
1. Reset: drive gate=1 and run to SUSTAIN, then pulse rst mid-cycle -> level, env, phase and dout read 0 and env_state=IDLE in the same cycle; the FSM restarts ATTACK on the first tick after release of rst with gate=1.
2. Saw: TICK_DIV=4, PHASE_W=16, DW=10, freq_word=64, wave_sel=0, env forced full (attack_rate=1023, sustain_lvl=1023), amp_in=16'hFFFF -> saw output increments by 1 every 4 clocks and wraps 1023 -> 0 after 1024 ticks.
3. ADSR: attack_rate=256, decay_rate=100, sustain_lvl=600, release_rate=300; gate high -> env 256, 512, 768, 1023 (DECAY), 923, 823, 723, 623, 600 (SUSTAIN); gate low -> 300, 0, IDLE.
4. Retrigger: gate low at env=600 -> RELEASE env=300; gate high next tick -> ATTACK from 300, giving 556 on the following tick.
5. PDM: hold level=512 (DW=10) -> exactly 512 ones in 1024 clocks; level=0 -> dout constantly 0.
6. Square/noise: wave_sel=1 at full env and amp -> level alternates 0 / ~1022 with period 2^PHASE_W/freq_word ticks; wave_sel=3 -> first noise samples match the LFSR sequence from seed 16'hACE1.
